// File: rtl/mem_banked_lanes_if.sv
// Warp request/response bundle for mem_banked_lanes: master = load/store stage, slave = memory.
interface mem_banked_lanes_if #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic                    req_valid;
  logic                    req_ready;
  logic [LANES-1:0]        req_mask;
  logic [LANES-1:0]        req_we;
  logic [LANES*ADDR_W-1:0] req_addr;
  logic [LANES*DATA_W-1:0] req_wdata;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [LANES*DATA_W-1:0] rsp_rdata;
  logic [LANES-1:0]        rsp_err;
  logic [7:0]              busy_cycles;

  modport master (
    output req_valid, req_mask, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy_cycles
  );

  modport slave (
    input  req_valid, req_mask, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy_cycles
  );
endinterface

// File: rtl/mem_banked_lanes.sv
// Banked warp scratch memory: serialises per-bank conflicts, returns one registered warp response.
// Optional MEM_BANKED_BROADCAST_EN: same-address pending reads ride along with a granted read.
module mem_banked_lanes #(
  parameter int LANES     = 4,
  parameter int DEPTH     = 48,
  parameter int NUM_BANKS = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_banked_lanes_if.slave  bus
);

  localparam logic [ADDR_W-1:0] BANK_MASK = ADDR_W'(NUM_BANKS - 1);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [LANES-1:0]        r_we;
  logic [LANES-1:0]        r_pending;
  logic [LANES*ADDR_W-1:0] r_addr;
  logic [LANES*DATA_W-1:0] r_wdata;
  logic [LANES*DATA_W-1:0] r_rdata;
  logic [LANES-1:0]        r_err;
  logic [7:0]              r_serve_cnt;
  logic [7:0]              r_busy_cycles;
  logic                    r_req_ready;
  logic                    r_rsp_valid;
  logic [DATA_W-1:0]       r_mem [DEPTH];

  logic                    w_accept;
  logic [LANES-1:0]        w_in_range;
  logic [LANES-1:0]        w_grant;
  logic                    w_serve_done;
`ifdef MEM_BANKED_BROADCAST_EN
  logic [LANES-1:0]        w_first;
`endif

  function automatic logic [ADDR_W-1:0] lane_addr(input logic [LANES*ADDR_W-1:0] vec, input int idx);
    return vec[idx*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_accept = bus.req_valid & r_req_ready;

  // Per-lane range check on the incoming request
  always_comb begin
    w_in_range = '0;
    for (int i = 0; i < LANES; i++) begin
      w_in_range[i] = ({1'b0, lane_addr(bus.req_addr, i)} < DEPTH_L);
    end
  end

  // Per bank, the lowest-index pending lane wins; broadcast adds matching reads
  always_comb begin
    w_grant = '0;
    for (int i = 0; i < LANES; i++) begin
      w_grant[i] = r_pending[i];
      for (int j = 0; j < i; j++) begin
        w_grant[i] = w_grant[i] & ~(r_pending[j] &
                     (((lane_addr(r_addr, i) ^ lane_addr(r_addr, j)) & BANK_MASK) == '0));
      end
    end
`ifdef MEM_BANKED_BROADCAST_EN
    w_first = w_grant;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        w_grant[i] = w_grant[i] | (r_pending[i] & ~r_we[i] & w_first[j] & ~r_we[j] &
                     (lane_addr(r_addr, i) == lane_addr(r_addr, j)));
      end
    end
`endif
  end

  assign w_serve_done = ((r_pending & ~w_grant) == '0);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if ((bus.req_mask & w_in_range) == '0) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_SERVE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SERVE: begin
        if (w_serve_done) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_SERVE;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, request latch, read capture and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_we          <= '0;
      r_pending     <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_err         <= '0;
      r_serve_cnt   <= 8'd0;
      r_busy_cycles <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_RESP);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we        <= bus.req_we;
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata;
            r_pending   <= bus.req_mask & w_in_range;
            r_err       <= bus.req_mask & ~w_in_range;
            r_rdata     <= '0;
            r_serve_cnt <= 8'd0;
            if ((bus.req_mask & w_in_range) == '0) begin
              r_busy_cycles <= 8'd0;
            end
          end
        end
        S_SERVE: begin
          r_pending   <= r_pending & ~w_grant;
          r_serve_cnt <= sat_inc(r_serve_cnt);
          for (int i = 0; i < LANES; i++) begin
            if (w_grant[i] && !r_we[i]) begin
              r_rdata[i*DATA_W +: DATA_W] <= r_mem[lane_addr(r_addr, i)];
            end
          end
          if (w_serve_done) begin
            r_busy_cycles <= sat_inc(r_serve_cnt);
          end
        end
        default: begin
          r_pending <= r_pending;
        end
      endcase
    end
  end

  // Storage is not reset; granted writes land at the serving edge
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (r_state == S_SERVE && w_grant[i] && r_we[i]) begin
        r_mem[lane_addr(r_addr, i)] <= r_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rdata;
  assign bus.rsp_err     = r_err;
  assign bus.busy_cycles = r_busy_cycles;

endmodule

// File: tb/tb_mem_banked_lanes.sv
// Bench for mem_banked_lanes: directed vector table, hand sequences, random traffic vs a queue model.
module tb_mem_banked_lanes;
  localparam int LANES = 4;
  localparam int DEPTH = 48;
  localparam int NB    = 4;
  localparam int DW    = 16;
  localparam int AW    = 6;
`ifdef MEM_BANKED_BROADCAST_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  typedef struct {
    logic [3:0]  mask;
    logic [3:0]  we;
    logic [23:0] a;
    logic [63:0] wd;
    logic [63:0] rd;
    logic [3:0]  err;
    logic [7:0]  busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [DW-1:0] m_mem [DEPTH];
  vec_t tbl [13];

  mem_banked_lanes_if #(.LANES(LANES), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_banked_lanes #(.LANES(LANES), .DEPTH(DEPTH), .NUM_BANKS(NB), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pk_a(input int a0, input int a1, input int a2, input int a3);
    return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  function automatic logic [63:0] pk_d(input int d0, input int d1, input int d2, input int d3);
    return {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Each bank is a queue of lanes in ascending order; one head leaves per bank per cycle.
  task automatic model_run(input logic [3:0] mask, input logic [3:0] we, input logic [23:0] a,
                           input logic [63:0] wd, output logic [63:0] rd, output logic [3:0] err,
                           output logic [7:0] busy);
    int q [NB][$];
    int cycles;
    int any;
    int h;
    logic [5:0]  ad [4];
    logic [15:0] w  [4];
    logic [15:0] rv [4];
    err = 4'd0;
    cycles = 0;
    for (int i = 0; i < LANES; i++) begin
      ad[i] = a[i*AW +: AW];
      w[i]  = wd[i*DW +: DW];
      rv[i] = 16'd0;
      if (mask[i]) begin
        if (int'(ad[i]) >= DEPTH) err[i] = 1'b1;
        else q[int'(ad[i]) % NB].push_back(i);
      end
    end
    for (int c = 0; c <= LANES; c++) begin
      any = 0;
      for (int b = 0; b < NB; b++) begin
        if (q[b].size() > 0) begin
          any = 1;
          h = q[b].pop_front();
          if (we[h]) begin
            m_mem[ad[h]] = w[h];
          end else begin
            rv[h] = m_mem[ad[h]];
            if (BC) begin
              for (int k = q[b].size() - 1; k >= 0; k--) begin
                if (!we[q[b][k]] && ad[q[b][k]] == ad[h]) begin
                  rv[q[b][k]] = rv[h];
                  q[b].delete(k);
                end
              end
            end
          end
        end
      end
      if (any != 0) cycles++;
    end
    rd = {rv[3], rv[2], rv[1], rv[0]};
    busy = (cycles > 255) ? 8'd255 : 8'(cycles);
  endtask

  task automatic run_req(input string nm, input logic [3:0] mask, input logic [3:0] we,
                         input logic [23:0] a, input logic [63:0] wd, input logic [63:0] exp_rd,
                         input logic [3:0] exp_err, input logic [7:0] exp_busy, input int hold);
    int edges;
    bit seen;
    @(negedge clk);
    chk({nm, "/req_ready_idle"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_mask  = mask;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    edges = 0;
    seen  = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) bus.req_valid = 1'b0;
      edges++;
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk({nm, "/latency"}, 64'(edges), 64'((exp_busy == 8'd0) ? 1 : int'(exp_busy) + 1));
    chk({nm, "/rdata"}, bus.rsp_rdata, exp_rd);
    chk({nm, "/err"}, 64'(bus.rsp_err), 64'(exp_err));
    chk({nm, "/busy"}, 64'(bus.busy_cycles), 64'(exp_busy));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk({nm, "/hold_valid"}, 64'(bus.rsp_valid), 64'd1);
      chk({nm, "/hold_ready"}, 64'(bus.req_ready), 64'd0);
      chk({nm, "/hold_rdata"}, bus.rsp_rdata, exp_rd);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk({nm, "/rsp_drop"}, 64'(bus.rsp_valid), 64'd0);
    chk({nm, "/req_ready_back"}, 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] mrd;
    logic [3:0]  merr;
    logic [7:0]  mbusy;
    logic [3:0]  rmask, rwe;
    logic [23:0] ra;
    logic [63:0] rwd;

    tbl[0]  = '{mask:4'hF, we:4'hF, a:pk_a(0,1,2,3), wd:pk_d('hA0,'hA1,'hA2,'hA3),
                rd:64'd0, err:4'd0, busy:8'd1};
    tbl[1]  = '{mask:4'hF, we:4'h0, a:pk_a(0,1,2,3), wd:64'd0,
                rd:pk_d('hA0,'hA1,'hA2,'hA3), err:4'd0, busy:8'd1};
    tbl[2]  = '{mask:4'h3, we:4'h3, a:pk_a(8,4,0,0), wd:pk_d('h1234,'h11,0,0),
                rd:64'd0, err:4'd0, busy:8'd2};
    tbl[3]  = '{mask:4'hF, we:4'h0, a:pk_a(8,8,8,8), wd:64'd0,
                rd:pk_d('h1234,'h1234,'h1234,'h1234), err:4'd0, busy:(BC ? 8'd1 : 8'd4)};
    tbl[4]  = '{mask:4'h7, we:4'h2, a:pk_a(4,4,4,0), wd:pk_d(0,'h55,0,0),
                rd:pk_d('h11, 0, (BC ? 'h11 : 'h55), 0), err:4'd0, busy:(BC ? 8'd2 : 8'd3)};
    tbl[5]  = '{mask:4'h1, we:4'h0, a:pk_a(4,0,0,0), wd:64'd0,
                rd:pk_d('h55,0,0,0), err:4'd0, busy:8'd1};
    tbl[6]  = '{mask:4'hA, we:4'hA, a:pk_a(0,12,0,12), wd:pk_d(0,'hAA,0,'hBB),
                rd:64'd0, err:4'd0, busy:8'd2};
    tbl[7]  = '{mask:4'h1, we:4'h0, a:pk_a(12,0,0,0), wd:64'd0,
                rd:pk_d('hBB,0,0,0), err:4'd0, busy:8'd1};
    tbl[8]  = '{mask:4'h5, we:4'hF, a:pk_a(16,12,18,12), wd:pk_d('h16,'hCC,'h18,'hDD),
                rd:64'd0, err:4'd0, busy:8'd1};
    tbl[9]  = '{mask:4'h7, we:4'h0, a:pk_a(12,16,18,0), wd:64'd0,
                rd:pk_d('hBB,'h16,'h18,0), err:4'd0, busy:8'd2};
    tbl[10] = '{mask:4'hF, we:4'h0, a:pk_a(0,1,48,3), wd:64'd0,
                rd:pk_d('hA0,'hA1,0,'hA3), err:4'h4, busy:8'd1};
    tbl[11] = '{mask:4'hF, we:4'h5, a:pk_a(48,50,60,63), wd:pk_d(1,2,3,4),
                rd:64'd0, err:4'hF, busy:8'd0};
    tbl[12] = '{mask:4'h0, we:4'hF, a:pk_a(0,1,2,3), wd:pk_d(5,6,7,8),
                rd:64'd0, err:4'd0, busy:8'd0};

    bus.req_valid = 1'b0;
    bus.req_mask  = 4'd0;
    bus.req_we    = 4'd0;
    bus.req_addr  = 24'd0;
    bus.req_wdata = 64'd0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/req_ready", 64'(bus.req_ready), 64'd1);
    chk("reset/rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset/rdata", bus.rsp_rdata, 64'd0);
    chk("reset/err", 64'(bus.rsp_err), 64'd0);
    chk("reset/busy", 64'(bus.busy_cycles), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < DEPTH / 4; k++) begin
      ra  = pk_a(4*k, 4*k+1, 4*k+2, 4*k+3);
      rwd = pk_d('h1000+4*k, 'h1001+4*k, 'h1002+4*k, 'h1003+4*k);
      model_run(4'hF, 4'hF, ra, rwd, mrd, merr, mbusy);
      run_req($sformatf("init%0d", k), 4'hF, 4'hF, ra, rwd, mrd, merr, mbusy, 0);
    end

    for (int k = 0; k < 13; k++) begin
      model_run(tbl[k].mask, tbl[k].we, tbl[k].a, tbl[k].wd, mrd, merr, mbusy);
      run_req($sformatf("vec%0d", k), tbl[k].mask, tbl[k].we, tbl[k].a, tbl[k].wd,
              tbl[k].rd, tbl[k].err, tbl[k].busy, (k == 1) ? 5 : 0);
    end

    // Reset one cycle into a four-deep same-bank write burst: only lane0's write survives
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_mask  = 4'hF;
    bus.req_we    = 4'hF;
    bus.req_addr  = pk_a(24, 28, 32, 36);
    bus.req_wdata = pk_d('h7001, 'h7002, 'h7003, 'h7004);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst/req_ready", 64'(bus.req_ready), 64'd1);
    chk("midrst/rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midrst/rdata", bus.rsp_rdata, 64'd0);
    chk("midrst/err", 64'(bus.rsp_err), 64'd0);
    chk("midrst/busy", 64'(bus.busy_cycles), 64'd0);
    m_mem[24] = 16'h7001;
    @(negedge clk);
    rst_n = 1'b1;
    model_run(4'hF, 4'h0, pk_a(24, 28, 32, 36), 64'd0, mrd, merr, mbusy);
    run_req("midrst/readback", 4'hF, 4'h0, pk_a(24, 28, 32, 36), 64'd0,
            pk_d('h7001, 'h101C, 'h1020, 'h1024), 4'd0, 8'd4, 0);

    for (int n = 0; n < 150; n++) begin
      rmask = 4'($urandom);
      rwe   = 4'($urandom);
      rwd   = {$urandom, $urandom};
      for (int i = 0; i < LANES; i++) begin
        if ($urandom_range(0, 9) == 0) ra[i*AW +: AW] = 6'($urandom_range(48, 63));
        else if ($urandom_range(0, 1) == 0) ra[i*AW +: AW] = 6'($urandom_range(0, 15));
        else ra[i*AW +: AW] = 6'($urandom_range(0, 47));
      end
      model_run(rmask, rwe, ra, rwd, mrd, merr, mbusy);
      run_req($sformatf("rand%0d", n), rmask, rwe, ra, rwd, mrd, merr, mbusy, n % 7 == 3 ? 2 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
